// File: rtl/datapath_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : datapath_pkg
//  Description : Shared datapath definitions: data word width, steering-select
//                encodings and the data word type used by the 1:2 demux.
//  Revision    : 1.0 - initial release
// ============================================================================
package datapath_pkg;

    localparam int   DATA_W = 64;

    // Per-beat destination select encodings
    localparam logic SEL_A  = 1'b0;
    localparam logic SEL_B  = 1'b1;

    typedef logic [DATA_W-1:0] data_word_t;

endpackage : datapath_pkg
`default_nettype wire

// File: rtl/demux_chan_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : demux_chan_fifo
//  Description : Per-channel FIFO for the 1:2 stream demux. Full/empty are
//                derived from the occupancy count; pointers wrap modulo DEPTH.
//  Ports       : clk, rst_n       - clock, async active-low reset
//                push_valid/data  - write request (ignored while full)
//                full             - count == DEPTH
//                pop_valid/ready  - head valid / consumer ready
//                pop_data         - head data (registered storage, no bypass)
//                count            - occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_chan_fifo
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_valid,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    output logic             pop_valid,
    input  logic             pop_ready,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count
);

    localparam int               PTR_W      = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] c_full_cnt = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign full      = (r_count == c_full_cnt);
    assign pop_valid = (r_count != '0);
    assign pop_data  = r_mem[r_rd_ptr];
    assign count     = r_count;

    // A push is refused while full even if a pop happens the same cycle;
    // this keeps the upstream ready free of any path from pop_ready.
    assign w_push = push_valid && !full;
    assign w_pop  = pop_valid && pop_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Storage is cleared so the head data port never shows X.
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : demux_chan_fifo
`default_nettype wire

// File: rtl/demux_64bit_stream.sv
`default_nettype none
// ============================================================================
//  Module      : demux_64bit_stream
//  Description : 1:2 stream steering block. Each source beat is routed to
//                channel A or B by in_sel and buffered in a per-channel FIFO
//                so a stalled consumer does not block the other side.
//  Ports       : clk, rst_n                   - clock, async active-low reset
//                in_valid/in_ready/in_sel/in_data - source beat
//                a_valid/a_ready/a_data       - channel A head
//                b_valid/b_ready/b_data       - channel B head
//                a_count/b_count              - channel occupancies
//  Revision    : 1.0 - initial release
// ============================================================================
module demux_64bit_stream
    import datapath_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             a_valid,
    input  logic             a_ready,
    output logic [WIDTH-1:0] a_data,
    output logic             b_valid,
    input  logic             b_ready,
    output logic [WIDTH-1:0] b_data,
    output logic [CNT_W-1:0] a_count,
    output logic [CNT_W-1:0] b_count
);

    logic w_sel_a;
    logic w_a_full;
    logic w_b_full;
    logic w_push_a;
    logic w_push_b;

    // in_ready depends only on in_sel and registered occupancy.
    assign w_sel_a  = (in_sel == SEL_A);
    assign in_ready = w_sel_a ? !w_a_full : !w_b_full;
    assign w_push_a = in_valid && in_ready &&  w_sel_a;
    assign w_push_b = in_valid && in_ready && !w_sel_a;

    demux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chan_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (w_push_a),
        .push_data  (in_data),
        .full       (w_a_full),
        .pop_valid  (a_valid),
        .pop_ready  (a_ready),
        .pop_data   (a_data),
        .count      (a_count)
    );

    demux_chan_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_chan_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (w_push_b),
        .push_data  (in_data),
        .full       (w_b_full),
        .pop_valid  (b_valid),
        .pop_ready  (b_ready),
        .pop_data   (b_data),
        .count      (b_count)
    );

endmodule : demux_64bit_stream
`default_nettype wire

// File: tb/tb_demux_64bit_stream.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_64bit_stream
//  Description : Self-checking bench for demux_64bit_stream (DEPTH = 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_demux_64bit_stream;
    import datapath_pkg::*;

    localparam int c_depth = 2;
    localparam int c_cnt_w = $clog2(c_depth) + 1;

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic               in_sel;
    data_word_t         in_data;
    logic               a_valid;
    logic               a_ready;
    data_word_t         a_data;
    logic               b_valid;
    logic               b_ready;
    data_word_t         b_data;
    logic [c_cnt_w-1:0] a_count;
    logic [c_cnt_w-1:0] b_count;

    int n_vec;
    int n_mis;

    demux_64bit_stream #(
        .WIDTH (DATA_W),
        .DEPTH (c_depth),
        .CNT_W (c_cnt_w)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sel   (in_sel),
        .in_data  (in_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs for one cycle plus the outputs expected just before its edge.
    typedef struct {
        logic       iv;
        logic       sel;
        data_word_t din;
        logic       ar;
        logic       br;
        logic       e_ir;
        logic       e_av;
        data_word_t e_ad;
        logic       e_bv;
        data_word_t e_bd;
        int         e_ac;
        int         e_bc;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(logic iv, logic sel, data_word_t din, logic ar, logic br,
                                logic ir, logic av, data_word_t ad, logic bv, data_word_t bd,
                                int ac, int bc);
        vec_t v;
        v.iv = iv;  v.sel = sel;  v.din = din;  v.ar = ar;  v.br = br;
        v.e_ir = ir; v.e_av = av; v.e_ad = ad; v.e_bv = bv; v.e_bd = bd;
        v.e_ac = ac; v.e_bc = bc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
            n_mis++;
        end
    endtask

    task automatic drive(input logic iv, input logic sel, input data_word_t d,
                         input logic ar, input logic br);
        @(negedge clk);
        in_valid = iv;
        in_sel   = sel;
        in_data  = d;
        a_ready  = ar;
        b_ready  = br;
        #1;
    endtask

    // Protocol monitor: in_sel must not change while a valid beat is stalled.
    logic r_prev_stall;
    logic r_prev_sel;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_stall <= 1'b0;
            r_prev_sel   <= 1'b0;
        end else begin
            if (r_prev_stall && in_valid && (in_sel != r_prev_sel)) begin
                $display("FAIL protocol: in_sel changed %b -> %b under stalled valid", r_prev_sel, in_sel);
                n_mis++;
            end
            r_prev_stall <= in_valid && !in_ready;
            r_prev_sel   <= in_sel;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        data_word_t d1;
        data_word_t d2;
        int         idx;
        int         na;
        int         nb;
        int         cyc;
        int         a_seen;

        n_vec = 0;
        n_mis = 0;
        d1 = 64'h0000_0000_DEAD_BEEF;
        d2 = 64'h1111_2222_3333_4444;

        // Reset/idle, single beats each side, A backpressure with B bypass,
        // full-with-pop cycle then push+pop with wrap.
        vecs[0]  = mk(0, 0, 0,    1, 1,  1, 0, 0,    0, 0,    0, 0);
        vecs[1]  = mk(0, 1, 0,    1, 1,  1, 0, 0,    0, 0,    0, 0);
        vecs[2]  = mk(1, 0, d1,   1, 1,  1, 0, 0,    0, 0,    0, 0);
        vecs[3]  = mk(1, 1, d2,   1, 1,  1, 1, d1,   0, 0,    1, 0);
        vecs[4]  = mk(0, 1, 0,    1, 1,  1, 0, 0,    1, d2,   0, 1);
        vecs[5]  = mk(0, 0, 0,    1, 1,  1, 0, 0,    0, 0,    0, 0);
        vecs[6]  = mk(1, 0, 1,    0, 1,  1, 0, 0,    0, 0,    0, 0);
        vecs[7]  = mk(1, 0, 2,    0, 1,  1, 1, 1,    0, 0,    1, 0);
        vecs[8]  = mk(1, 0, 3,    0, 1,  0, 1, 1,    0, 0,    2, 0);
        vecs[9]  = mk(0, 1, 0,    0, 1,  1, 1, 1,    0, 0,    2, 0);
        vecs[10] = mk(1, 1, 'h55, 0, 0,  1, 1, 1,    0, 0,    2, 0);
        vecs[11] = mk(0, 0, 0,    1, 0,  0, 1, 1,    1, 'h55, 2, 1);
        vecs[12] = mk(0, 0, 0,    1, 1,  1, 1, 2,    1, 'h55, 1, 1);
        vecs[13] = mk(1, 0, 3,    1, 1,  1, 0, 0,    0, 0,    0, 0);
        vecs[14] = mk(0, 0, 0,    0, 1,  1, 1, 3,    0, 0,    1, 0);
        vecs[15] = mk(1, 0, 'h10, 0, 1,  1, 1, 3,    0, 0,    1, 0);
        vecs[16] = mk(1, 0, 'h11, 1, 1,  0, 1, 3,    0, 0,    2, 0);
        vecs[17] = mk(1, 0, 'h11, 1, 1,  1, 1, 'h10, 0, 0,    1, 0);
        vecs[18] = mk(0, 0, 0,    1, 1,  1, 1, 'h11, 0, 0,    1, 0);
        vecs[19] = mk(0, 0, 0,    1, 1,  1, 0, 0,    0, 0,    0, 0);

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b0;
        in_data  = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        chk("rst_a_valid", {63'd0, a_valid}, 64'd0);
        chk("rst_b_valid", {63'd0, b_valid}, 64'd0);
        chk("rst_a_data",  a_data, 64'd0);
        chk("rst_b_data",  b_data, 64'd0);
        chk("rst_a_count", 64'(a_count), 64'd0);
        chk("rst_b_count", 64'(b_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(vecs[i].iv, vecs[i].sel, vecs[i].din, vecs[i].ar, vecs[i].br);
            n_vec++;
            chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].e_ir});
            chk($sformatf("v%0d_a_valid", i),  {63'd0, a_valid},  {63'd0, vecs[i].e_av});
            chk($sformatf("v%0d_b_valid", i),  {63'd0, b_valid},  {63'd0, vecs[i].e_bv});
            chk($sformatf("v%0d_a_count", i),  64'(a_count), 64'(vecs[i].e_ac));
            chk($sformatf("v%0d_b_count", i),  64'(b_count), 64'(vecs[i].e_bc));
            if (vecs[i].e_av) chk($sformatf("v%0d_a_data", i), a_data, vecs[i].e_ad);
            if (vecs[i].e_bv) chk($sformatf("v%0d_b_data", i), b_data, vecs[i].e_bd);
        end

        // Alternating 16-beat stream under random backpressure.
        idx = 0;
        na  = 0;
        nb  = 0;
        cyc = 0;
        while ((idx < 16 || na < 8 || nb < 8) && cyc < 400) begin
            drive(idx < 16, idx[0], data_word_t'(idx),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (a_valid && a_ready) begin
                n_vec++;
                chk($sformatf("stream_a%0d", na), a_data, 64'(2 * na));
                na++;
            end
            if (b_valid && b_ready) begin
                n_vec++;
                chk($sformatf("stream_b%0d", nb), b_data, 64'(2 * nb + 1));
                nb++;
            end
            if (in_valid && in_ready) idx++;
            cyc++;
        end
        n_vec++;
        chk("stream_a_total", 64'(na), 64'd8);
        chk("stream_b_total", 64'(nb), 64'd8);
        chk("stream_beats",   64'(idx), 64'd16);

        // Mid-operation asynchronous reset with A = 2, B = 1.
        drive(1, 0, 64'hA1, 0, 0);
        drive(1, 0, 64'hA2, 0, 0);
        drive(1, 1, 64'hB1, 0, 0);
        drive(0, 1, 0, 0, 0);
        n_vec++;
        chk("pre_rst_a_count", 64'(a_count), 64'd2);
        chk("pre_rst_b_count", 64'(b_count), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        chk("arst_a_valid", {63'd0, a_valid}, 64'd0);
        chk("arst_b_valid", {63'd0, b_valid}, 64'd0);
        chk("arst_a_count", 64'(a_count), 64'd0);
        chk("arst_b_count", 64'(b_count), 64'd0);
        chk("arst_a_data",  a_data, 64'd0);
        chk("arst_b_data",  b_data, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        drive(1, 0, 64'hAA, 1, 1);
        n_vec++;
        chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("post_rst_a_valid",  {63'd0, a_valid},  64'd0);
        a_seen = 0;
        for (int k = 0; k < 5; k++) begin
            drive(0, 0, 0, 1, 1);
            if (a_valid) begin
                n_vec++;
                chk("post_rst_a_data", a_data, 64'hAA);
                a_seen++;
            end
            n_vec++;
            chk($sformatf("post_rst_b_valid%0d", k), {63'd0, b_valid}, 64'd0);
        end
        n_vec++;
        chk("post_rst_a_beats", 64'(a_seen), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule : tb_demux_64bit_stream
`default_nettype wire

// File: doc/demux_64bit_stream.md
Name: demux_64bit_stream

Overview:
- 1:2 steering block, the inverse of the datapath's 64-bit 2:1 select: one 64-bit source is routed to one of two destinations (A or B) by a per-beat select.
- Each destination channel has a small FIFO, so a stalled consumer on one side does not lose data. The other side keeps flowing as long as the producer's select points to it.
- Sits between a result producer (ALU/load path) and two consumers, e.g. register write-back and a store/forward path.

Parameters:
- WIDTH, 64, data width in bits.
- DEPTH, 2, entries per channel FIFO; power of two, ≥2.
- CNT_W, $clog2(DEPTH)+1, occupancy count width.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  source beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready at clk edge.
- in_sel  in  1  0 = channel A, 1 = channel B; sampled with the beat.
- in_data  in  WIDTH  source data.
- a_valid  out  1  channel A head valid.
- a_ready  in  1  channel A consumer ready.
- a_data  out  WIDTH  channel A head data.
- b_valid  out  1  channel B head valid.
- b_ready  in  1  channel B consumer ready.
- b_data  out  WIDTH  channel B head data.
- a_count  out  CNT_W  channel A occupancy.
- b_count  out  CNT_W  channel B occupancy.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all FIFO pointers and counts = 0; a_valid = b_valid = 0; a_count = b_count = 0. a_data/b_data are don't-care but must not be X on the ports; they are reset to 0.
- in_ready = (in_sel == 0) ? (a_count != DEPTH) : (b_count != DEPTH).
  - Combinational from in_sel and registered counts only; no path from a_ready/b_ready to in_ready.
- Push: on in_valid && in_ready, in_data is written to the tail of the selected channel; that count increments.
- Pop: a_valid = (a_count != 0); on a_valid && a_ready, the head advances and the count decrements. Channel B is identical.
- Latency: a beat accepted at edge N is visible on x_valid/x_data after edge N (1 cycle); no combinational pass-through.
- Ordering: strict FIFO order within each channel. There is no ordering relation between channels.
- Simultaneous push and pop on one channel:
  - Count unchanged.
  - When count == DEPTH, push is not allowed even if a pop occurs the same cycle (in_ready already 0).
  - When count == 0, a push and pop in the same cycle cannot occur (x_valid = 0).
- Simultaneous activity on both channels: a push to A plus a pop from B, or the reverse, is independent.
- Pointer wrap: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty come from count, not pointer compare.
- Data stability: x_data holds while x_valid && !x_ready.
- Select stability: in_sel must be stable while in_valid && !in_ready.
  - The producer may change in_sel while in_valid is held low.
  - The bench flags an in_sel change under a stalled valid as a protocol error.
- Reset mid-operation: all in-flight entries are discarded immediately; outputs return to reset values within the same delta.

Decomposition:
- Shared package datapath_pkg holds:
  - DATA_W = 64.
  - SEL_A = 1'b0, SEL_B = 1'b1.
  - a typedef for a 64-bit data word.
- One sub-module, demux_chan_fifo (WIDTH, DEPTH), is instantiated twice. Its ports are push_valid/push_data/full, pop_valid/pop_ready/pop_data, and count.
- The top level is select decode, in_ready mux and two instances.

Test Plan:
1. Reset then idle → a_valid = b_valid = 0, counts 0, in_ready = 1 for both in_sel values.
2. Push 0x0000_0000_DEAD_BEEF sel=0, then 0x1111_2222_3333_4444 sel=1, both consumers ready → A shows DEAD_BEEF one cycle after accept, B shows 0x1111_2222_3333_4444 one cycle after its accept; counts return to 0.
3. a_ready = 0; push 3 beats sel=0 (values 1, 2, 3) → first two accepted, a_count = 2, in_ready = 0 for sel=0. Switch to sel=1 with 0x55 → accepted at once, b_valid next cycle. Raise a_ready → A drains 1 then 2, then beat 3 accepted.
4. Channel A full with a_ready = 1 and in_valid sel=0 in the same cycle → that cycle pops only, in_ready = 0, a_count 2→1; the next cycle push and pop happen together and a_count stays 1.
5. Stream 16 beats alternating sel 0/1 with values 0..15, random ready backpressure → A receives 0, 2, 4…14 and B receives 1, 3…15 in order, with no loss and no duplicates.
6. Assert rst_n low with a_count = 2 and b_count = 1 → outputs and counts go to 0 asynchronously. After release the next push of 0xAA sel=0 is the only A output.
